// File: rtl/arb_pkg.sv
// Shared types and default widths for the memory port arbiter and the
// Controller/datapath that talks to it.
package arb_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_param_chk.sv
// Elaboration-time parameter checks for mem_port_arbiter.
module arb_param_chk #(
  parameter int MEM_LAT         = 2,
  parameter int MAX_DATA_STREAK = 4
) ();

  if (MEM_LAT < 1) begin : g_lat_bad
    $fatal(1, "mem_port_arbiter: MEM_LAT must be at least 1");
  end

  if (MAX_DATA_STREAK < 1) begin : g_streak_bad
    $fatal(1, "mem_port_arbiter: MAX_DATA_STREAK must be at least 1");
  end

endmodule

// File: rtl/lat_counter.sv
// Loadable down-counter that times the memory access; zero marks the last
// BUSY cycle.
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load wins over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data path.
// Data has priority; a streak counter bounds how long fetch can be starved.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MEM_LAT         = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              if_gnt,
  output logic              d_gnt,
  output logic              if_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              MEM_read,
  output logic              MEM_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W  = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STRK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CNT_W-1:0]  LOAD_VAL  = CNT_W'(MEM_LAT - 1);
  localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(MAX_DATA_STREAK);

  arb_state_t        state_r, state_nxt_s;
  arb_owner_t        owner_r, owner_nxt_s;
  logic              we_r, we_nxt_s;
  logic [STRK_W-1:0] streak_r, streak_nxt_s;
  logic              grant_s, capture_s, d_win_s;
  logic              cnt_zero_s, cnt_en_s;

  arb_param_chk #(.MEM_LAT(MEM_LAT), .MAX_DATA_STREAK(MAX_DATA_STREAK)) u_chk ();

  assign cnt_en_s = (state_r == ARB_BUSY) && !cnt_zero_s;

  lat_counter #(.W(CNT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_s),
    .load_val (LOAD_VAL),
    .en       (cnt_en_s),
    .zero     (cnt_zero_s)
  );

  // Arbitration, next-state and streak bookkeeping.
  always_comb begin
    state_nxt_s  = state_r;
    owner_nxt_s  = owner_r;
    we_nxt_s     = we_r;
    streak_nxt_s = streak_r;
    grant_s      = 1'b0;
    capture_s    = 1'b0;
    d_win_s      = d_req && !(if_req && (streak_r == STRK_MAX));
    case (state_r)
      ARB_IDLE: begin
        if (d_win_s) begin
          grant_s     = 1'b1;
          state_nxt_s = ARB_BUSY;
          owner_nxt_s = OWN_D;
          we_nxt_s    = d_we;
          if (if_req && (streak_r != STRK_MAX)) begin
            streak_nxt_s = streak_r + STRK_W'(1);
          end else if (if_req) begin
            streak_nxt_s = streak_r;
          end else begin
            streak_nxt_s = {STRK_W{1'b0}};
          end
        end else if (if_req) begin
          grant_s      = 1'b1;
          state_nxt_s  = ARB_BUSY;
          owner_nxt_s  = OWN_IF;
          we_nxt_s     = 1'b0;
          streak_nxt_s = {STRK_W{1'b0}};
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (cnt_zero_s) begin
          state_nxt_s = ARB_DONE;
          capture_s   = !we_r;
        end else begin
          state_nxt_s = ARB_BUSY;
        end
      end
      ARB_DONE: state_nxt_s = ARB_IDLE;
      default:  state_nxt_s = ARB_IDLE;
    endcase
  end

  // State, latches and outputs; outputs decode the next state so they are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ARB_IDLE;
      owner_r   <= OWN_IF;
      we_r      <= 1'b0;
      streak_r  <= {STRK_W{1'b0}};
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      rdata     <= {DATA_W{1'b0}};
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      MEM_read  <= 1'b0;
      MEM_write <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      we_r     <= we_nxt_s;
      streak_r <= streak_nxt_s;
      if (grant_s) begin
        mem_addr <= (owner_nxt_s == OWN_D) ? d_addr : if_addr;
        if (owner_nxt_s == OWN_D) begin
          mem_wdata <= d_wdata;
        end
      end
      if (capture_s) begin
        rdata <= mem_rdata;
      end
      if_gnt    <= (state_nxt_s != ARB_IDLE) && (owner_nxt_s == OWN_IF);
      d_gnt     <= (state_nxt_s != ARB_IDLE) && (owner_nxt_s == OWN_D);
      if_done   <= (state_nxt_s == ARB_DONE) && (owner_nxt_s == OWN_IF);
      d_done    <= (state_nxt_s == ARB_DONE) && (owner_nxt_s == OWN_D);
      MEM_read  <= (state_nxt_s == ARB_BUSY) && !we_nxt_s;
      MEM_write <= (state_nxt_s == ARB_BUSY) && we_nxt_s;
    end
  end

endmodule
